// File: rtl/fib_pkg.sv
// Shared types, default widths and the round-robin pick helper for the fib engine arbiter.
package fib_pkg;

  localparam int unsigned FIB_N1 = 8;
  localparam int unsigned FIB_N2 = 32;
  localparam int unsigned RR_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Returns {found, idx}: first set bit of req scanning from ptr upward, modulo nreq.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned nreq);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      cand = 3'((32'(ptr) + k) % nreq);
      if (!found && (k < nreq) && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: grants the first requester at or after ptr.
module rr_arb
  import fib_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            found
);

  logic [3:0] pick;

  always_comb begin
    pick       = rr_pick(8'(req), 3'(ptr), NREQ);
    found      = pick[3];
    gnt_idx    = IDW'(pick[2:0]);
    gnt_onehot = found ? (NREQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/fib_arbiter.sv
// Shares one Fibonacci engine among NREQ requesters with round-robin grants,
// one job in flight, and routes each result back to the requester that issued it.
module fib_arbiter
  import fib_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned N1   = FIB_N1,
  parameter  int unsigned N2   = FIB_N2,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_vld,
  input  logic [NREQ*N1-1:0] req_n,
  output logic [NREQ-1:0]    req_rdy,
  output logic [NREQ-1:0]    rsp_vld,
  output logic [N2-1:0]      rsp_data,
  input  logic [NREQ-1:0]    rsp_rdy,
  output logic             eng_vld_in,
  output logic [N1-1:0]    eng_fib_in,
  input  logic             eng_rdy_in,
  input  logic             eng_vld_out,
  input  logic [N2-1:0]    eng_fib_out,
  output logic             eng_rdy_out,
  output logic             busy,
  output logic [IDW-1:0]   owner
);

  arb_state_t     state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] owner_q;
  logic [N1-1:0]  n_lat_q;

  logic [NREQ-1:0] gnt_onehot;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_found;
  logic [N1-1:0]   req_n_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_n_arr[i] = req_n[i*N1 +: N1];
  end

  rr_arb #(
    .NREQ(NREQ)
  ) u_rr_arb (
    .req       (req_vld),
    .ptr       (rr_ptr_q),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .found     (gnt_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      n_lat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A found grant is always a handshake: req_rdy mirrors the grant in IDLE.
          if (gnt_found) begin
            n_lat_q <= req_n_arr[gnt_idx];
            owner_q <= gnt_idx;
            if (32'(gnt_idx) == NREQ - 1) begin
              rr_ptr_q <= '0;
            end else begin
              rr_ptr_q <= gnt_idx + IDW'(1);
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (eng_rdy_in) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (eng_vld_out && rsp_rdy[owner_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result path is a straight pass-through so the requester sees it the same cycle.
  always_comb begin
    req_rdy     = '0;
    rsp_vld     = '0;
    rsp_data    = '0;
    eng_vld_in  = 1'b0;
    eng_fib_in  = '0;
    eng_rdy_out = 1'b0;
    case (state_q)
      IDLE: req_rdy = gnt_onehot;
      ISSUE: begin
        eng_vld_in = 1'b1;
        eng_fib_in = n_lat_q;
      end
      WAIT: begin
        rsp_vld     = eng_vld_out ? (NREQ'(1) << owner_q) : '0;
        rsp_data    = eng_fib_out;
        eng_rdy_out = rsp_rdy[owner_q];
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule

// File: doc/fib_arbiter.md
Name: fib_arbiter

Overview:
- Shares one fib engine (instance of the team's 8-bit-in / 32-bit-out Fibonacci core) among NREQ requesters.
- Round-robin arbitration; one job in flight at a time.
- Sequences the engine's valid/ready input and output handshakes and routes each result back to the requester that issued it.
- Sits between client blocks and the single engine instance at the top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- N1, 8, width of requested index n.
- N2, 32, width of Fibonacci result.
- IDW, $clog2(NREQ), derived: owner index width (not overridable).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_vld  in  NREQ  per-requester request valid.
- req_n  in  NREQ*N1  packed request indices; requester i at bits [i*N1 +: N1].
- req_rdy  out  NREQ  per-requester accept, one-hot or zero.
- rsp_vld  out  NREQ  per-requester result valid, one-hot or zero.
- rsp_data  out  N2  shared result bus, meaningful only where rsp_vld is set.
- rsp_rdy  in  NREQ  per-requester result accept.
- eng_vld_in  out  1  to engine: index valid.
- eng_fib_in  out  N1  to engine: index.
- eng_rdy_in  in  1  from engine: ready for index.
- eng_vld_out  in  1  from engine: result valid (held until accepted).
- eng_fib_out  in  N2  from engine: result.
- eng_rdy_out  out  1  to engine: result accept.
- busy  out  1  high whenever state is not IDLE.
- owner  out  IDW  index of the requester currently being served (valid while busy).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, rr_ptr=0, owner=0, n_lat=0.
  - All outputs 0: req_rdy, rsp_vld, rsp_data, eng_vld_in, eng_fib_in, eng_rdy_out, busy.
  - The engine shares rst_n, so it is also reset.
  - Reset mid-job discards the job. No response is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Grant g = first i with req_vld[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_rdy[g]=1 combinationally, from req_vld and rr_ptr only; all other req_rdy bits are 0.
  - On handshake: latch n_lat=req_n[g] and owner=g; set rr_ptr=(g+1) mod NREQ; go to ISSUE.
  - With no req_vld, stay in IDLE and leave rr_ptr unchanged.
- ISSUE:
  - eng_vld_in=1, eng_fib_in=n_lat.
  - When eng_rdy_in=1 in the same cycle, go to WAIT. Otherwise hold.
  - req_rdy=0 throughout.
- WAIT:
  - rsp_vld[owner]=eng_vld_out, rsp_data=eng_fib_out, eng_rdy_out=rsp_rdy[owner].
  - This is a pass-through with no added register stage.
  - When eng_vld_out and rsp_rdy[owner] are both 1, go to IDLE.
  - rsp_rdy on non-owner lines is ignored.
- Outside WAIT: rsp_vld=0 and rsp_data=0.
- Latency:
  - Requester accept to eng_vld_in is 1 cycle.
  - Result to requester is 0 cycles after eng_vld_out.
  - Back-to-back jobs: IDLE re-arbitrates in the cycle after the result handshake.
  - Minimum gap is therefore 1 idle cycle per job.
- Fairness:
  - A requester holding req_vld is granted within NREQ grants.
  - A requester may drop req_vld before grant with no effect.
- Requester-side protocol rules (checked by assertions, not by RTL):
  - req_vld and req_n stay stable until req_rdy.
  - rsp_rdy may be asserted early.
- Width rules:
  - Indices pass through unmodified.
  - Results beyond 2^N2 wrap exactly as the engine produces them; no saturation.
- Simultaneous events:
  - Requests arriving during ISSUE or WAIT are not accepted and wait for IDLE.
  - A requester may present a new req_vld in the same cycle its rsp handshake completes; it is arbitrated next cycle.
- Illegal state encoding returns to IDLE.

Decomposition:
- Package fib_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT};
  - default widths FIB_N1=8, FIB_N2=32;
  - function rr_pick(req, ptr) returning {found, idx}.
- One sub-module is natural: rr_arb, a combinational round-robin picker (NREQ parameter; inputs req and ptr; outputs gnt_onehot, gnt_idx, found).
- The FSM, latches and routing stay in fib_arbiter.
- The bench instantiates fib_arbiter plus the real engine.

Test Plan:
- Single requester 0, n=10 → rsp_vld[0] with rsp_data=55; busy falls 1 cycle after the rsp handshake; rr_ptr=1.
- Boundary indices n=0, n=1, n=47 on requester 2 → results 0, 1, 2971215073 in order; owner=2 each time.
- All 4 requesters assert req_vld continuously with n=5,6,7,8 → grants in order 0,1,2,3,0 …; results 5,8,13,21 routed to the correct rsp_vld bit; no other rsp_vld bit ever rises.
- Requester 1 holds rsp_rdy=0 for 20 cycles after its result (n=12) → rsp_vld[1] and rsp_data=144 remain stable and eng_rdy_out stays 0; requester 3's pending request is not accepted until the release.
- Reset asserted during WAIT for n=40 → all outputs 0 next cycle; no rsp_vld for that job; a new request n=3 then returns 2.
- Assertions throughout: req_rdy and rsp_vld are at most one-hot; eng_vld_in is stable until eng_rdy_in; a requester requesting alone is granted within NREQ grants.
